mips_fetch_unit: RTL

Instruction-fetch front end of the MIPS core: the initiator side of the combinational instruction-RAM read port. It owns the program counter and drives `instr_address`. It presents `instr_readdata` to decode and applies branch/jump redirects with one architectural delay slot. It halts the core after a jump to address 0, once the delay slot has issued.

---
 rtl/mips_fetch_pkg.sv | 15 +
 rtl/mips_fetch_unit_if.sv | 18 +
 rtl/mips_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction-fetch unit: state encoding and
// architectural constants used by the fetch unit, the CPU top and benches.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] MIPS_HALT_ADDR    = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES       = 32'd4;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Combinational instruction-RAM read port: fetch drives the address, RAM
// returns the word in the same cycle.
interface mips_fetch_unit_if;

  logic [31:0] instr_address;
  logic [31:0] instr_readdata;

  modport master (
    output instr_address,
    input  instr_readdata
  );

  modport slave (
    input  instr_address,
    output instr_readdata
  );

endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS fetch front end: PC, one-slot branch delay, halt on jump to HALT_ADDR.
// Optional misaligned-target trap enabled by defining MIPS_FETCH_ALIGN_CHECK_EN.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = MIPS_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = MIPS_HALT_ADDR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  mips_fetch_unit_if.master        bus,
  output logic [31:0]              instr,
  output logic                     instr_valid,
  output logic [31:0]              pc,
  output logic [31:0]              link_addr,
  input  logic                     redirect,
  input  logic [31:0]              redirect_target,
  output logic                     active,
  output logic [31:0]              fetch_count,
  output logic                     fetch_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  count_q, count_d;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
  logic         fault_q, fault_d;
`endif

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path can infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    count_d  = count_q;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    fault_d  = fault_q;
`endif

    if (clk_enable) begin
      unique case (state_q)
        RUN: begin
          pc_d    = pc_q + INSTR_BYTES;
          count_d = count_q + 32'd1;
          if (redirect) begin
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
            target_d = redirect_target;
`else
            target_d = {redirect_target[31:2], 2'b00};
`endif
            state_d  = DELAY;
          end
        end

        // Delay slot is issuing; any redirect it raises is dropped.
        DELAY: begin
          count_d = count_q + 32'd1;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
          if (target_q[1:0] != 2'b00) begin
            pc_d    = pc_q + INSTR_BYTES;
            fault_d = 1'b1;
            state_d = HALTED;
          end else begin
            pc_d    = target_q;
            state_d = (target_q == HALT_ADDR) ? HALTED : RUN;
          end
`else
          pc_d    = target_q;
          state_d = (target_q == HALT_ADDR) ? HALTED : RUN;
`endif
        end

        default: ; // HALTED: hold until reset
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_VECTOR;
      target_q <= '0;
      count_q  <= '0;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      count_q  <= count_d;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
      fault_q  <= fault_d;
`endif
    end
  end

  // Outputs depend on registers only, except the instruction pass-through.
  assign bus.instr_address = pc_q;
  assign pc                = pc_q;
  assign link_addr         = pc_q + 32'd8;
  assign instr             = bus.instr_readdata;
  assign active            = (state_q != HALTED);
  assign instr_valid       = active;
  assign fetch_count       = count_q;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
  assign fetch_fault       = fault_q;
`else
  assign fetch_fault       = 1'b0;
`endif

endmodule
